// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer_if
// Brief    : Handshake bundle between the instruction sequencer and the
//            fetch / execute FSMs of the 16-bit shared-bus CPU.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             run;
    logic             fetch_done;
    logic [3:0]       opcode;
    logic             move_done;
    logic             movi_done;
    logic             alu_done;
    logic             alui_done;

    logic             start_fetch;
    logic             start_move;
    logic             start_movi;
    logic             start_alu;
    logic             start_alui;
    logic             busy;
    logic             halted;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] instr_count;

    // Sequencer side
    modport master (
        input  run, fetch_done, opcode,
        input  move_done, movi_done, alu_done, alui_done,
        output start_fetch, start_move, start_movi, start_alu, start_alui,
        output busy, halted, fault, fault_code, instr_count
    );

    // Fetch / execute FSM side
    modport slave (
        output run, fetch_done, opcode,
        output move_done, movi_done, alu_done, alui_done,
        input  start_fetch, start_move, start_movi, start_alu, start_alui,
        input  busy, halted, fault, fault_code, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Central fetch/decode/execute sequencer with halt, illegal-opcode
//            trap, per-phase watchdog and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_sequencer_if.master  bus
);

    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_HALT   = 3'd4;
    localparam logic [2:0] c_FAULT  = 3'd5;

    // One-hot execute unit, bit order {alui, alu, movi, move}
    localparam logic [3:0] c_U_NONE = 4'b0000;
    localparam logic [3:0] c_U_MOVE = 4'b0001;
    localparam logic [3:0] c_U_MOVI = 4'b0010;
    localparam logic [3:0] c_U_ALU  = 4'b0100;
    localparam logic [3:0] c_U_ALUI = 4'b1000;

    localparam logic [1:0] c_FC_NONE  = 2'b00;
    localparam logic [1:0] c_FC_WDOG  = 2'b01;
    localparam logic [1:0] c_FC_ILLEG = 2'b10;
    localparam logic [1:0] c_FC_WRONG = 2'b11;

    logic [2:0]       state_q, state_d;
    logic [3:0]       unit_q, unit_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             start_fetch_q, start_fetch_d;
    logic [3:0]       start_exec_q, start_exec_d;
    logic             busy_q, busy_d;
    logic             halted_q, halted_d;
    logic             fault_q, fault_d;

    logic [3:0]       w_dones;
    logic             w_match;
    logic             w_other;
    logic             w_expire;

    assign w_dones  = {bus.alui_done, bus.alu_done, bus.movi_done, bus.move_done};
    assign w_match  = |(w_dones & unit_q);
    assign w_other  = |(w_dones & ~unit_q);
    assign w_expire = (timer_q == c_TMR_LAST);

    always_comb begin
        state_d = state_q;
        unit_d  = unit_q;
        code_d  = code_q;
        count_d = count_q;

        case (state_q)
            c_IDLE: begin
                if (bus.run) begin
                    state_d = c_FETCH;
                end
            end

            c_FETCH: begin
                // A done on the expiry cycle still counts as in time
                if (bus.fetch_done) begin
                    state_d = c_DECODE;
                end else if (w_expire) begin
                    state_d = c_FAULT;
                    code_d  = c_FC_WDOG;
                end
            end

            c_DECODE: begin
                if (bus.opcode == 4'h0) begin
                    state_d = c_EXEC;
                    unit_d  = c_U_MOVE;
                end else if (bus.opcode == 4'h1) begin
                    state_d = c_EXEC;
                    unit_d  = c_U_MOVI;
                end else if (bus.opcode <= 4'h7) begin
                    state_d = c_EXEC;
                    unit_d  = c_U_ALU;
                end else if (bus.opcode <= 4'hD) begin
                    state_d = c_EXEC;
                    unit_d  = c_U_ALUI;
                end else if (bus.opcode == 4'hE) begin
                    state_d = c_FAULT;
                    code_d  = c_FC_ILLEG;
                end else begin
                    state_d = c_HALT;
                    count_d = count_q + 1'b1;
                end
            end

            c_EXEC: begin
                if (w_match) begin
                    count_d = count_q + 1'b1;
                    unit_d  = c_U_NONE;
                    state_d = bus.run ? c_FETCH : c_IDLE;
                end else if (w_other) begin
                    state_d = c_FAULT;
                    code_d  = c_FC_WRONG;
                end else if (w_expire) begin
                    state_d = c_FAULT;
                    code_d  = c_FC_WDOG;
                end
            end

            c_HALT:  state_d = c_HALT;
            c_FAULT: state_d = c_FAULT;
            default: state_d = c_IDLE;
        endcase
    end

    // Timer restarts on every state change so each FETCH/EXEC entry gets a full budget
    always_comb begin
        timer_d = '0;
        if ((state_d == state_q) && ((state_q == c_FETCH) || (state_q == c_EXEC))) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_comb begin
        start_fetch_d = (state_d == c_FETCH) && (state_q != c_FETCH);
        start_exec_d  = ((state_d == c_EXEC) && (state_q != c_EXEC)) ? unit_d : c_U_NONE;
        busy_d        = (state_d == c_FETCH) || (state_d == c_DECODE) || (state_d == c_EXEC);
        halted_d      = (state_d == c_HALT);
        fault_d       = (state_d == c_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= c_IDLE;
            unit_q        <= c_U_NONE;
            timer_q       <= '0;
            code_q        <= c_FC_NONE;
            count_q       <= '0;
            start_fetch_q <= 1'b0;
            start_exec_q  <= c_U_NONE;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            unit_q        <= unit_d;
            timer_q       <= timer_d;
            code_q        <= code_d;
            count_q       <= count_d;
            start_fetch_q <= start_fetch_d;
            start_exec_q  <= start_exec_d;
            busy_q        <= busy_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.start_fetch = start_fetch_q;
    assign bus.start_move  = start_exec_q[0];
    assign bus.start_movi  = start_exec_q[1];
    assign bus.start_alu   = start_exec_q[2];
    assign bus.start_alui  = start_exec_q[3];
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Self-checking bench for instr_sequencer with a transaction-level
//            reference model (TIMEOUT=8, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_sequencer_if #(.CNT_W(CNT_W)) sif ();

    instr_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int checks      = 0;
    int errors      = 0;
    int model_count = 0;
    int cur_unit    = 0;

    logic [4:0] starts;
    assign starts = {sif.start_alui, sif.start_alu, sif.start_movi, sif.start_move, sif.start_fetch};

    // Opcode class: 0 move, 1 movi, 2 alu, 3 alui, 4 halt, 5 illegal
    function automatic int unit_of(input logic [3:0] op);
        if (op == 4'd0) return 0;
        if (op == 4'd1) return 1;
        if (op >= 4'd2 && op <= 4'd7) return 2;
        if (op >= 4'd8 && op <= 4'd13) return 3;
        if (op == 4'd14) return 5;
        return 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_dones();
        sif.fetch_done = 1'b0;
        sif.move_done  = 1'b0;
        sif.movi_done  = 1'b0;
        sif.alu_done   = 1'b0;
        sif.alui_done  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_starts"}, starts, 0);
        chk({tag, "_busy"}, sif.busy, 0);
        chk({tag, "_halted"}, sif.halted, 0);
        chk({tag, "_fault"}, sif.fault, 0);
        chk({tag, "_code"}, sif.fault_code, 0);
        chk({tag, "_count"}, sif.instr_count, 0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        sif.run = 1'b0;
        clear_dones();
        sif.opcode = 4'($urandom);
        step();
        step();
        reset = 1'b0;
        model_count = 0;
        chk_all_zero("reset");
    endtask

    task automatic start_run();
        sif.run = 1'b1;
        step();
        chk("start_fetch", starts, 5'b00001);
        chk("fetch_busy", sif.busy, 1);
    endtask

    // Entered in the start_fetch cycle; fetch_done arrives flat cycles later
    task automatic fetch_decode(input logic [3:0] op, input int flat);
        for (int i = 0; i < flat; i++) begin
            step();
            chk("fetch_wait_starts", starts, 0);
            chk("fetch_wait_fault", sif.fault, 0);
        end
        sif.fetch_done = 1'b1;
        sif.opcode     = op;
        step();
        sif.fetch_done = 1'b0;
        chk("decode_busy", sif.busy, 1);
        chk("decode_starts", starts, 0);
        step();
        sif.opcode = 4'($urandom);
        cur_unit   = unit_of(op);
        if (cur_unit < 4) begin
            chk("exec_start", starts, 32'(2 << cur_unit));
            chk("exec_busy", sif.busy, 1);
        end else if (cur_unit == 4) begin
            model_count++;
            chk("halt_halted", sif.halted, 1);
            chk("halt_busy", sif.busy, 0);
            chk("halt_starts", starts, 0);
            chk("halt_count", sif.instr_count, model_count % (1 << CNT_W));
        end else begin
            chk("illegal_fault", sif.fault, 1);
            chk("illegal_code", sif.fault_code, 2);
            chk("illegal_starts", starts, 0);
            chk("illegal_count", sif.instr_count, model_count % (1 << CNT_W));
        end
    endtask

    // Entered in the start_x cycle; done from unit du arrives elat cycles later
    task automatic exec_done(input int elat, input int du);
        logic r;
        for (int i = 0; i < elat; i++) begin
            step();
            chk("exec_wait_starts", starts, 0);
            chk("exec_wait_fault", sif.fault, 0);
        end
        case (du)
            0:       sif.move_done = 1'b1;
            1:       sif.movi_done = 1'b1;
            2:       sif.alu_done  = 1'b1;
            default: sif.alui_done = 1'b1;
        endcase
        r = sif.run;
        step();
        clear_dones();
        if (du == cur_unit) begin
            model_count++;
            chk("retire_count", sif.instr_count, model_count % (1 << CNT_W));
            chk("retire_next_fetch", starts, r ? 1 : 0);
            chk("retire_busy", sif.busy, r ? 1 : 0);
            chk("retire_fault", sif.fault, 0);
        end else begin
            chk("wrong_fault", sif.fault, 1);
            chk("wrong_code", sif.fault_code, 3);
            chk("wrong_starts", starts, 0);
            chk("wrong_count", sif.instr_count, model_count % (1 << CNT_W));
        end
    endtask

    task automatic sticky_check(input string tag, input int cycles, input int halted, input int code);
        for (int i = 0; i < cycles; i++) begin
            sif.fetch_done = 1'($urandom);
            sif.move_done  = 1'($urandom);
            sif.alu_done   = 1'($urandom);
            step();
            chk({tag, "_starts"}, starts, 0);
            chk({tag, "_halted"}, sif.halted, halted);
            chk({tag, "_code"}, sif.fault_code, code);
        end
        clear_dones();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset      = 1'b1;
        sif.run    = 1'b0;
        sif.opcode = 4'd0;
        clear_dones();
        do_reset();

        // Basic move: fetch_done 3 cycles after start_fetch, move_done 2 after start_move
        start_run();
        fetch_decode(4'h0, 3);
        exec_done(2, 0);
        fetch_decode(4'h1, 2);
        exec_done(1, 1);
        fetch_decode(4'h5, 1);
        exec_done(3, 2);
        fetch_decode(4'hA, 4);
        exec_done(1, 3);

        // Random legal instructions; enough retires to wrap the 4-bit counter
        for (int n = 0; n < 16; n++) begin
            fetch_decode(4'($urandom_range(0, 13)), $urandom_range(1, 7));
            exec_done($urandom_range(1, 7), cur_unit);
        end

        // run dropped during EXEC: instruction completes, then IDLE
        fetch_decode(4'h3, 2);
        sif.run = 1'b0;
        exec_done(2, cur_unit);
        sif.fetch_done = 1'b1;
        sif.move_done  = 1'b1;
        step();
        clear_dones();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_starts", starts, 0);
            chk("idle_busy", sif.busy, 0);
            chk("idle_fault", sif.fault, 0);
        end
        start_run();

        // Halt: sticky, counts as retired, no further starts
        fetch_decode(4'hF, 2);
        sticky_check("halt_hold", 20, 1, 0);
        do_reset();

        // Illegal opcode trap
        start_run();
        fetch_decode(4'hE, 3);
        sticky_check("illegal_hold", 4, 0, 2);
        do_reset();

        // Wrong unit done
        start_run();
        fetch_decode(4'h0, 2);
        exec_done(2, 2);
        sticky_check("wrong_hold", 4, 0, 3);
        do_reset();

        // Fetch watchdog: no fetch_done, fault visible after 8 cycles in FETCH
        start_run();
        for (int i = 2; i <= TIMEOUT; i++) begin
            step();
            chk("wdog_pending_fault", sif.fault, 0);
            chk("wdog_pending_busy", sif.busy, 1);
        end
        step();
        chk("wdog_fault", sif.fault, 1);
        chk("wdog_code", sif.fault_code, 1);
        chk("wdog_busy", sif.busy, 0);
        do_reset();

        // Done on the expiry cycle wins, in both FETCH and EXEC
        start_run();
        fetch_decode(4'h0, TIMEOUT - 1);
        exec_done(TIMEOUT - 1, 0);

        // Exec watchdog
        fetch_decode(4'h3, 1);
        for (int i = 2; i <= TIMEOUT; i++) begin
            step();
            chk("exec_wdog_pending", sif.fault, 0);
        end
        step();
        chk("exec_wdog_fault", sif.fault, 1);
        chk("exec_wdog_code", sif.fault_code, 1);
        do_reset();

        // Reset mid-EXEC
        start_run();
        fetch_decode(4'h9, 2);
        step();
        reset = 1'b1;
        step();
        model_count = 0;
        chk_all_zero("mid_exec_reset");
        reset   = 1'b0;
        sif.run = 1'b0;
        step();
        chk_all_zero("after_mid_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Central instruction sequencer for the 16-bit shared-bus CPU. It issues one-cycle start pulses to the fetch FSM and to exactly one execute FSM (move, movi, ALU, ALUI), and checks the matching done. It replaces the free-running OR of done signals that currently restarts fetch, and adds a halt opcode, an illegal-opcode trap, a per-phase watchdog and a retired-instruction counter.

## Interface
Parameters:
- TIMEOUT, 64, max cycles spent in FETCH or EXEC before a watchdog fault (≥2)
- CNT_W, 16, width of instr_count

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
- fetch_done  in  1  pulse from fetch FSM, IR valid
- opcode  in  4  IR[15:12]
- move_done, movi_done, alu_done, alui_done  in  1 each  completion pulses from execute FSMs
- start_fetch  out  1  one-cycle pulse
- start_move, start_movi, start_alu, start_alui  out  1 each  one-cycle pulses, at most one high per cycle
- busy  out  1  high in FETCH, DECODE, EXEC
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- fault_code  out  2  01 watchdog, 10 illegal opcode, 11 wrong unit done; 00 otherwise
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, FETCH, DECODE, EXEC, HALT, FAULT.
- Reset (any state, any cycle, including mid-instruction): state = IDLE. All outputs 0, instr_count = 0, watchdog timer = 0, latched unit = none.
- IDLE: run=1 → FETCH. run=0 → stay.
- FETCH: fetch_done=1 → DECODE. fetch_done is ignored in every other state.
- DECODE (exactly 1 cycle). Opcode is sampled here and the selected unit is latched:
  - 0000 → EXEC, move
  - 0001 → EXEC, movi
  - 0010–0111 → EXEC, ALU
  - 1000–1101 → EXEC, ALUI
  - 1110 → FAULT, code 10
  - 1111 → HALT; instr_count increments (HALT counts as retired)
- EXEC:
  - Done from the latched unit → instr_count+1; then run=1 → FETCH, run=0 → IDLE.
  - Done from any other unit (and no matching done that cycle) → FAULT, code 11.
- HALT and FAULT are sticky until reset. Only reset clears fault_code and halted.
- Watchdog:
  - Timer clears on every entry to FETCH or EXEC and increments each cycle spent there.
  - If the timer equals TIMEOUT-1 and no valid done arrives that cycle → FAULT, code 01.
  - A valid done in the same cycle as expiry wins; no fault.
- Start pulses are registered. Each is high for exactly the first cycle of its FETCH/EXEC state entry, and never again while in that state.
- Done inputs arriving in IDLE, DECODE, HALT or FAULT are ignored.
- run dropping mid-instruction does not abort; the current instruction completes.

## Timing
- run sampled 1 at edge k in IDLE → start_fetch high in cycle k+1.
- fetch_done at cycle n → DECODE in n+1 → start_x high in n+2.
- Matching done at cycle m → instr_count updated and start_fetch high in m+1 (if run=1).
- Minimum per-instruction overhead is 3 cycles beyond the FSM latencies: DECODE, plus one start cycle each for fetch and execute.
- Watchdog: FAULT is entered at the edge ending the TIMEOUT-th cycle in the state. fault is visible in the next cycle.
- instr_count at 2^CNT_W−1 plus a retire → 0. No flag.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- Reset, run=1, fetch_done 3 cycles after start_fetch, opcode 0000, move_done 2 cycles after start_move → start_fetch cycle 1, start_move 2 cycles after fetch_done, instr_count=1, second start_fetch one cycle after move_done.
- Opcodes 0001, 0101, 1010 in sequence → start_movi, start_alu, start_alui respectively, each exactly one cycle wide; instr_count=3.
- Opcode 1111 → halted=1, busy=0, instr_count increments, no further start pulses for 20 cycles; then reset → halted=0, instr_count=0.
- Opcode 1110 → fault=1, fault_code=10. Opcode 0000 answered by alu_done → fault_code=11.
- TIMEOUT=8, start_fetch issued and no fetch_done → fault_code=01 after 8 cycles in FETCH. Repeat with fetch_done on cycle 8 → no fault, DECODE entered.
- CNT_W=4: retire 17 instructions → instr_count=1. run dropped during EXEC → instruction completes, IDLE entered, no start_fetch. Reset asserted mid-EXEC → IDLE next cycle, all outputs 0.
